// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: round-robin scheduler sharing one SPI transfer engine among
// NREQ requesters. It runs a four-phase enable/ready handshake with the engine:
// xfer_en feeds the enable synchronizer and xfer_ack is the engine ready,
// already synchronized into pclk.
//
// Optional feature: define SPI_SCHED_TIMEOUT_EN to add a per-phase watchdog.
// When it expires, the transfer is forced to DONE and err pulses together with
// done. Without the macro, REQ/REL wait forever and err is tied low.
//
// Handshake: xfer_en rises in REQ and stays high until xfer_ack is seen high.
// The FSM then waits in REL for xfer_ack to fall before issuing done. A new
// grant is never made while xfer_ack is still high.
//
// state_dbg exposes the FSM state: 0=IDLE 1=REQ 2=REL 3=DONE.
module spi_xfer_sched #(
  parameter int NREQ     = 4,
  parameter int TO_W     = 8,
  parameter int TO_LIMIT = 200
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            xfer_en,
  input  logic            xfer_ack,
  output logic            done,
  output logic            err,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic            xfer_en_q, done_q, err_q, err_d;
  logic [PW-1:0]   arb_win;
  logic            arb_found;
  logic            wd_expired;

  // Round-robin pick: first set req bit at or after the pointer, wrapping.
  always_comb begin
    int            idx;
    logic [PW-1:0] cand;
    arb_win   = '0;
    arb_found = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = idx[PW-1:0];
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_win   = cand;
      end
    end
  end

`ifdef SPI_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] wd_q, wd_d;

  // The phase has used its whole budget on the cycle the count hits TO_LIMIT-1.
  assign wd_expired = (wd_q == TO_W'(TO_LIMIT - 1));

  // Watchdog counts cycles spent in the current REQ or REL phase; any phase change clears it.
  always_comb begin
    wd_d = '0;
    if ((state_q == REQ || state_q == REL) && state_d == state_q)
      wd_d = wd_q + 1'b1;
  end

  // Watchdog register.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign wd_expired = 1'b0;
`endif

  // Next-state, grant and pointer decisions.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A stale-high ack would confuse the next handshake, so hold off.
        if (arb_found && !xfer_ack) begin
          gnt_d          = '0;
          gnt_d[arb_win] = 1'b1;
          win_d          = arb_win;
          state_d        = REQ;
        end
      end
      REQ: begin
        if (xfer_ack) begin
          state_d = REL;
        end else if (wd_expired) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      REL: begin
        if (!xfer_ack) begin
          state_d = DONE;
        end else if (wd_expired) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        gnt_d   = '0;
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they come straight from flops (xfer_en crosses into another clock domain).
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= '0;
      win_q     <= '0;
      xfer_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      xfer_en_q <= (state_d == REQ);
      done_q    <= (state_d == DONE);
      err_q     <= err_d;
    end
  end

  assign gnt       = gnt_q;
  assign xfer_en   = xfer_en_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed testbench for spi_xfer_sched (NREQ=4, TO_LIMIT=200).
// Inputs are driven and outputs sampled on the falling edge of pclk.
module tb_spi_xfer_sched;

  logic       pclk;
  logic       preset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       xfer_en;
  logic       xfer_ack;
  logic       done;
  logic       err;
  logic       busy;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: grants expected, in order.
  logic [3:0] exp_q[$];

  spi_xfer_sched #(.NREQ(4), .TO_W(8), .TO_LIMIT(200)) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req       (req),
    .gnt       (gnt),
    .xfer_en   (xfer_en),
    .xfer_ack  (xfer_ack),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock and overall time bound.
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Invariants on every cycle: gnt zero or one-hot, xfer_en only while busy and not done.
  always @(negedge pclk) begin
    if (!preset) begin
      check("inv_gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (xfer_en) check("inv_en_in_req", {30'd0, busy, done}, 32'd2);
    end
  end

  // One complete transfer for the next expected grant. ack follows xfer_en
  // edges by lat cycles; req is set to req_after on the done cycle.
  task automatic do_xfer(input int lat, input logic [3:0] req_after);
    logic [3:0] exp;
    int n;
    exp = exp_q.pop_front();
    n = 0;
    do begin @(negedge pclk); n++; end while (!xfer_en && n < 20);
    check("grant_latency", n, 1);
    check("gnt", 32'(gnt), 32'(exp));
    check("busy_in_xfer", 32'(busy), 1);
    repeat (lat - 1) @(negedge pclk);
    xfer_ack = 1'b1;
    n = 0;
    do begin @(negedge pclk); n++; end while (xfer_en && n < 20);
    check("en_drop_latency", n, 1);
    check("gnt_in_rel", 32'(gnt), 32'(exp));
    repeat (lat - 1) @(negedge pclk);
    xfer_ack = 1'b0;
    @(negedge pclk);
    check("done_pulse", 32'(done), 1);
    check("err_on_done", 32'(err), 0);
    check("gnt_at_done", 32'(gnt), 32'(exp));
    req = req_after;
    @(negedge pclk);
    check("done_one_cycle", 32'(done), 0);
    check("idle_after_done", 32'(busy), 0);
    check("gnt_clear", 32'(gnt), 0);
  endtask

  initial begin
    int n;
    int cnt;
    logic err_seen;
    preset   = 1'b1;
    req      = 4'b0000;
    xfer_ack = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_xfer_en", 32'(xfer_en), 0);
    check("rst_done_err_busy", {29'd0, done, err, busy}, 0);
    check("rst_state", 32'(state_dbg), 0);
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    check("idle_no_req", 32'(busy), 0);

    // 1: single requester, ack 4 cycles after each xfer_en edge.
    req = 4'b0001;
    exp_q.push_back(4'b0001);
    do_xfer(4, 4'b0000);

    // Reset while idle to return the pointer to 0.
    preset = 1'b1;
    @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);

    // 2: all four requesting; order 0,1,2,3 then 0 again, one idle cycle between.
    req = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int i = 0; i < 4; i++) do_xfer(2, 4'b1111);
    do_xfer(2, 4'b0000);

    // 3: move pointer to 2, then req=1011 grants 3, then 0, then 1.
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    do_xfer(1, 4'b0000);
    req = 4'b1011;
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    do_xfer(2, 4'b0011);
    do_xfer(2, 4'b0010);
    do_xfer(2, 4'b0000);

    // 4: stale ack blocks arbitration until it drops.
    xfer_ack = 1'b1;
    req = 4'b0010;
    repeat (4) @(negedge pclk);
    check("stale_ack_no_gnt", 32'(gnt), 0);
    check("stale_ack_idle", {30'd0, busy, xfer_en}, 0);
    xfer_ack = 1'b0;
    exp_q.push_back(4'b0010);
    do_xfer(3, 4'b0000);

    // 5: reset in the middle of REQ aborts asynchronously with no done.
    req = 4'b1000;
    n = 0;
    do begin @(negedge pclk); n++; end while (!xfer_en && n < 20);
    check("pre_rst_grant", 32'(gnt), 32'(4'b1000));
    #2;
    preset = 1'b1;
    #1;
    check("async_rst_gnt", 32'(gnt), 0);
    check("async_rst_en", 32'(xfer_en), 0);
    check("async_rst_flags", {29'd0, done, err, busy}, 0);
    @(negedge pclk);
    check("rst_hold_done", 32'(done), 0);
    preset = 1'b0;
    req = 4'b0101;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    do_xfer(2, 4'b0100);
    do_xfer(4, 4'b0000);

    // 6: engine never acknowledges.
    req = 4'b0011;
    n = 0;
    do begin @(negedge pclk); n++; end while (!xfer_en && n < 20);
    check("to_grant", 32'(gnt), 32'(4'b0001));
`ifdef SPI_SCHED_TIMEOUT_EN
    cnt = 1;
    while (xfer_en && cnt < 300) begin
      @(negedge pclk);
      if (xfer_en) cnt++;
    end
    check("to_en_cycles", cnt, 200);
    check("to_done_err", {30'd0, done, err}, 3);
    check("to_gnt_at_done", 32'(gnt), 32'(4'b0001));
    req = 4'b0010;
    @(negedge pclk);
    check("to_err_one_cycle", {30'd0, done, err}, 0);
    exp_q.push_back(4'b0010);
    do_xfer(2, 4'b0000);
`else
    err_seen = 1'b0;
    for (int i = 0; i < 250; i++) begin
      @(negedge pclk);
      if (err || done) err_seen = 1'b1;
    end
    check("no_to_en_held", 32'(xfer_en), 1);
    check("no_to_err", 32'(err_seen), 0);
    xfer_ack = 1'b1;
    @(negedge pclk);
    check("no_to_en_drop", 32'(xfer_en), 0);
    xfer_ack = 1'b0;
    @(negedge pclk);
    check("no_to_done", {30'd0, done, err}, 2);
    req = 4'b0010;
    @(negedge pclk);
    exp_q.push_back(4'b0010);
    do_xfer(2, 4'b0000);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
